// File: rtl/mem_pkg.sv
// Shared types and widths for the Avalon memory responder and its storage.
package mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    ACK   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_byte_array.sv
// Word memory split into byte-wide lanes: one lane-masked write port and one
// registered read port. Contents are never reset.
module mem_byte_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [BE_W-1:0]   we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    logic [BYTE_W-1:0] lane_mem [0:DEPTH-1];
    logic [BYTE_W-1:0] q_reg;

    always_ff @(posedge clk) begin
      if (we[gi]) begin
        lane_mem[waddr] <= wdata[BYTE_W*gi +: BYTE_W];
      end
      q_reg <= lane_mem[raddr];
    end

    assign rdata[BYTE_W*gi +: BYTE_W] = q_reg;
  end

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM slave memory with a fixed number of stall cycles per transfer,
// address-window decode and a sticky protocol/range error flag.
module avalon_mem_responder
  import mem_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       address,
  input  logic              read,
  input  logic              write,
  input  logic [WORD_W-1:0] writedata,
  input  logic [BE_W-1:0]   byteenable,
  output logic              waitrequest,
  output logic [WORD_W-1:0] readdata,
  output logic              err
);

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic [31:0]       addr_reg;
  logic [WORD_W-1:0] wdata_reg;
  logic [BE_W-1:0]   be_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic              is_read_reg;
  logic              is_write_reg;
  logic              oor_reg;
  logic              waitrequest_reg;
  logic              rd_valid_reg;
  logic              err_reg;

  // 33-bit subtraction so addresses below the base show up as a borrow.
  logic [32:0]       offset_next;
  logic              in_range_next;
  logic [ADDR_W-1:0] idx_next;
  logic [ADDR_W-1:0] raddr;
  logic              mem_write;
  logic [BE_W-1:0]   lane_we;
  logic [WORD_W-1:0] mem_q;

  assign offset_next   = {1'b0, address} - {1'b0, BASE_ADDR};
  assign in_range_next = !offset_next[32] &&
                         ((offset_next[31:0] >> (ADDR_W + 2)) == 32'd0);
  assign idx_next      = offset_next[ADDR_W+1:2];

  // Read the incoming word during IDLE so a zero-wait read has data in ACK.
  assign raddr     = (state_reg == IDLE) ? idx_next : idx_reg;
  assign mem_write = (state_reg == ACK) && is_write_reg && !oor_reg && reset;
  assign lane_we   = be_reg & {BE_W{mem_write}};

  mem_byte_array #(
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (lane_we),
    .waddr(idx_reg),
    .wdata(wdata_reg),
    .raddr(raddr),
    .rdata(mem_q)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= 4'd0;
      addr_reg        <= 32'd0;
      wdata_reg       <= '0;
      be_reg          <= '0;
      idx_reg         <= '0;
      is_read_reg     <= 1'b0;
      is_write_reg    <= 1'b0;
      oor_reg         <= 1'b0;
      waitrequest_reg <= 1'b1;
      rd_valid_reg    <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (read || write) begin
            addr_reg     <= address;
            wdata_reg    <= writedata;
            be_reg       <= byteenable;
            idx_reg      <= idx_next;
            is_read_reg  <= read;
            is_write_reg <= write && !read;
            oor_reg      <= !in_range_next;
            cnt_reg      <= 4'(WAIT_CYCLES);
            if (!in_range_next || (read && write)) begin
              err_reg <= 1'b1;
            end
            if (WAIT_CYCLES == 0) begin
              state_reg       <= ACK;
              waitrequest_reg <= 1'b0;
              rd_valid_reg    <= read && in_range_next;
            end else begin
              state_reg <= STALL;
            end
          end
        end

        STALL: begin
          if (address != addr_reg) begin
            err_reg <= 1'b1;
          end
          // A master that abandons the request mid-stall gets nothing back.
          if (!read && !write) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            is_read_reg  <= 1'b0;
            is_write_reg <= 1'b0;
            err_reg      <= 1'b1;
          end else if (cnt_reg <= 4'd1) begin
            state_reg       <= ACK;
            cnt_reg         <= 4'd0;
            waitrequest_reg <= 1'b0;
            rd_valid_reg    <= is_read_reg && !oor_reg;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end

        ACK: begin
          state_reg       <= IDLE;
          waitrequest_reg <= 1'b1;
          rd_valid_reg    <= 1'b0;
          is_read_reg     <= 1'b0;
          is_write_reg    <= 1'b0;
        end

        default: begin
          state_reg       <= IDLE;
          waitrequest_reg <= 1'b1;
          rd_valid_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign waitrequest = waitrequest_reg;
  assign readdata    = rd_valid_reg ? mem_q : '0;
  assign err         = err_reg;

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Bench for avalon_mem_responder: a 2-wait-state and a 0-wait-state instance,
// expected read data queued at issue and compared at completion.
module tb_avalon_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] writedata = 32'd0;
  logic [3:0]  byteenable = 4'd0;
  logic        read0 = 1'b0, write0 = 1'b0, read2 = 1'b0, write2 = 1'b0;
  logic        waitrequest0, waitrequest2, err0, err2;
  logic [31:0] readdata0, readdata2;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model0 [int];
  logic [31:0] model2 [int];

  always #5 clk = ~clk;

  avalon_mem_responder #(.ADDR_W(10), .BASE_ADDR(32'hBFC00000), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(rst_n), .address(address), .read(read2), .write(write2),
    .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest2), .readdata(readdata2), .err(err2)
  );

  avalon_mem_responder #(.ADDR_W(10), .BASE_ADDR(32'hBFC00000), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst_n), .address(address), .read(read0), .write(write0),
    .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest0), .readdata(readdata0), .err(err0)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  // Drives one transfer on the selected instance and waits for completion.
  task automatic bus_xfer(input bit sel, input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be,
                          output logic [31:0] rdata, output int waits, output bit stray);
    bit done;
    done = 1'b0; waits = 0; stray = 1'b0; rdata = 32'd0;
    @(posedge clk); #1;
    address = addr; writedata = wd; byteenable = be;
    if (sel) begin read2 = rd; write2 = wr; end else begin read0 = rd; write0 = wr; end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((sel ? waitrequest2 : waitrequest0) === 1'b0) begin
        rdata = sel ? readdata2 : readdata0;
        done = 1'b1;
        break;
      end
      waits++;
      if ((sel ? readdata2 : readdata0) !== 32'd0) stray = 1'b1;
    end
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL timeout: no completion for addr %h (waitrequest stuck, required 0)", addr);
    end
    @(posedge clk); #1;
    if (sel) begin read2 = 1'b0; write2 = 1'b0; end else begin read0 = 1'b0; write0 = 1'b0; end
    $display("xfer dut%0d rd=%0b wr=%0b addr=%h wd=%h be=%b -> rdata=%h waits=%0d",
             sel ? 2 : 0, rd, wr, addr, wd, be, rdata, waits);
  endtask

  task automatic test_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++; if (waitrequest2 !== 1'b1) begin n_errors++; $display("FAIL reset_wait2: got %b want 1", waitrequest2); end
    n_checks++; if (readdata2 !== 32'd0) begin n_errors++; $display("FAIL reset_rdata2: got %h want 0", readdata2); end
    n_checks++; if (err2 !== 1'b0) begin n_errors++; $display("FAIL reset_err2: got %b want 0", err2); end
    n_checks++; if (waitrequest0 !== 1'b1) begin n_errors++; $display("FAIL reset_wait0: got %b want 1", waitrequest0); end
    n_checks++; if (err0 !== 1'b0) begin n_errors++; $display("FAIL reset_err0: got %b want 0", err0); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_full_write();
    logic [31:0] rdata, exp; int waits; bit stray;
    exp_q.push_back(32'd0);
    bus_xfer(1, 1'b0, 1'b1, 32'hBFC00004, 32'hDEADBEEF, 4'hF, rdata, waits, stray);
    model2[1] = 32'hDEADBEEF;
    exp = exp_q.pop_front();
    n_checks++; if (waits !== 3) begin n_errors++; $display("FAIL write_stall: got %0d want 3", waits); end
    n_checks++; if (rdata !== exp) begin n_errors++; $display("FAIL write_ack_rdata: got %h want %h", rdata, exp); end
    exp_q.push_back(model2[1]);
    bus_xfer(1, 1'b1, 1'b0, 32'hBFC00004, 32'd0, 4'h0, rdata, waits, stray);
    exp = exp_q.pop_front();
    n_checks++; if (rdata !== exp) begin n_errors++; $display("FAIL read_full: got %h want %h", rdata, exp); end
    n_checks++; if (waits !== 3) begin n_errors++; $display("FAIL read_stall: got %0d want 3", waits); end
    n_checks++; if (stray !== 1'b0) begin n_errors++; $display("FAIL rdata_outside_ack: got %b want 0", stray); end
    exp_q.push_back(model2[1]);
    bus_xfer(1, 1'b1, 1'b0, 32'hBFC00007, 32'd0, 4'h0, rdata, waits, stray);
    exp = exp_q.pop_front();
    n_checks++; if (rdata !== exp) begin n_errors++; $display("FAIL read_low_bits: got %h want %h", rdata, exp); end
    n_checks++; if (err2 !== 1'b0) begin n_errors++; $display("FAIL err_clean: got %b want 0", err2); end
  endtask

  task automatic test_partial_write();
    logic [31:0] rdata, exp; int waits; bit stray;
    bus_xfer(1, 1'b0, 1'b1, 32'hBFC00004, 32'h11223344, 4'b0101, rdata, waits, stray);
    model2[1] = merge(model2[1], 32'h11223344, 4'b0101);
    exp_q.push_back(model2[1]);
    bus_xfer(1, 1'b1, 1'b0, 32'hBFC00004, 32'd0, 4'h0, rdata, waits, stray);
    exp = exp_q.pop_front();
    n_checks++; if (rdata !== exp) begin n_errors++; $display("FAIL partial: got %h want %h", rdata, exp); end
    bus_xfer(1, 1'b0, 1'b1, 32'hBFC00004, 32'h00000000, 4'b0000, rdata, waits, stray);
    exp_q.push_back(32'hDE22BE44);
    bus_xfer(1, 1'b1, 1'b0, 32'hBFC00004, 32'd0, 4'h0, rdata, waits, stray);
    exp = exp_q.pop_front();
    n_checks++; if (rdata !== exp) begin n_errors++; $display("FAIL be_zero: got %h want %h", rdata, exp); end
  endtask

  task automatic test_range();
    logic [31:0] rdata, exp; int waits; bit stray;
    bus_xfer(1, 1'b0, 1'b1, 32'hBFC00FFC, 32'h0F0E0D0C, 4'hF, rdata, waits, stray);
    model2[1023] = 32'h0F0E0D0C;
    bus_xfer(1, 1'b0, 1'b1, 32'hBFC00000, 32'h01020304, 4'hF, rdata, waits, stray);
    model2[0] = 32'h01020304;
    exp_q.push_back(model2[1023]);
    bus_xfer(1, 1'b1, 1'b0, 32'hBFC00FFC, 32'd0, 4'h0, rdata, waits, stray);
    exp = exp_q.pop_front();
    n_checks++; if (rdata !== exp) begin n_errors++; $display("FAIL top_word: got %h want %h", rdata, exp); end
    n_checks++; if (err2 !== 1'b0) begin n_errors++; $display("FAIL top_word_err: got %b want 0", err2); end
    bus_xfer(1, 1'b0, 1'b1, 32'hBFC01000, 32'hFFFFFFFF, 4'hF, rdata, waits, stray);
    n_checks++; if (waits !== 3) begin n_errors++; $display("FAIL oor_timing: got %0d want 3", waits); end
    n_checks++; if (err2 !== 1'b1) begin n_errors++; $display("FAIL oor_write_err: got %b want 1", err2); end
    exp_q.push_back(model2[0]);
    bus_xfer(1, 1'b1, 1'b0, 32'hBFC00000, 32'd0, 4'h0, rdata, waits, stray);
    exp = exp_q.pop_front();
    n_checks++; if (rdata !== exp) begin n_errors++; $display("FAIL oor_write_dropped: got %h want %h", rdata, exp); end
    n_checks++; if (err2 !== 1'b1) begin n_errors++; $display("FAIL err_sticky: got %b want 1", err2); end
    apply_reset();
    n_checks++; if (err2 !== 1'b0) begin n_errors++; $display("FAIL err_cleared: got %b want 0", err2); end
    exp_q.push_back(32'd0);
    bus_xfer(1, 1'b1, 1'b0, 32'h00000000, 32'd0, 4'h0, rdata, waits, stray);
    exp = exp_q.pop_front();
    n_checks++; if (rdata !== exp) begin n_errors++; $display("FAIL oor_read_data: got %h want %h", rdata, exp); end
    n_checks++; if (err2 !== 1'b1) begin n_errors++; $display("FAIL oor_read_err: got %b want 1", err2); end
    bus_xfer(1, 1'b1, 1'b0, 32'hBFC00004, 32'd0, 4'h0, rdata, waits, stray);
    n_checks++; if (err2 !== 1'b1) begin n_errors++; $display("FAIL err_hold: got %b want 1", err2); end
    apply_reset();
  endtask

  task automatic test_rw_both();
    logic [31:0] rdata, exp; int waits; bit stray;
    bus_xfer(1, 1'b0, 1'b1, 32'hBFC00008, 32'h55667788, 4'hF, rdata, waits, stray);
    model2[2] = 32'h55667788;
    exp_q.push_back(model2[2]);
    bus_xfer(1, 1'b1, 1'b1, 32'hBFC00008, 32'hFFFFFFFF, 4'hF, rdata, waits, stray);
    exp = exp_q.pop_front();
    n_checks++; if (rdata !== exp) begin n_errors++; $display("FAIL rw_read: got %h want %h", rdata, exp); end
    n_checks++; if (err2 !== 1'b1) begin n_errors++; $display("FAIL rw_err: got %b want 1", err2); end
    apply_reset();
    exp_q.push_back(model2[2]);
    bus_xfer(1, 1'b1, 1'b0, 32'hBFC00008, 32'd0, 4'h0, rdata, waits, stray);
    exp = exp_q.pop_front();
    n_checks++; if (rdata !== exp) begin n_errors++; $display("FAIL rw_no_write: got %h want %h", rdata, exp); end
  endtask

  task automatic test_drop();
    logic [31:0] rdata, exp; int waits; bit stray; bit acked;
    bus_xfer(1, 1'b0, 1'b1, 32'hBFC0000C, 32'h13579BDF, 4'hF, rdata, waits, stray);
    model2[3] = 32'h13579BDF;
    @(posedge clk); #1;
    address = 32'hBFC0000C; writedata = 32'h2468ACE0; byteenable = 4'hF; write2 = 1'b1;
    @(posedge clk); #1 write2 = 1'b0;
    acked = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (waitrequest2 === 1'b0) acked = 1'b1;
    end
    $display("xfer dut2 write dropped during stall addr=bfc0000c");
    n_checks++; if (acked !== 1'b0) begin n_errors++; $display("FAIL drop_no_ack: got %b want 0", acked); end
    n_checks++; if (err2 !== 1'b1) begin n_errors++; $display("FAIL drop_err: got %b want 1", err2); end
    exp_q.push_back(model2[3]);
    bus_xfer(1, 1'b1, 1'b0, 32'hBFC0000C, 32'd0, 4'h0, rdata, waits, stray);
    exp = exp_q.pop_front();
    n_checks++; if (rdata !== exp) begin n_errors++; $display("FAIL drop_no_write: got %h want %h", rdata, exp); end
    apply_reset();
  endtask

  task automatic test_addr_change();
    logic [31:0] rdata, exp; bit done;
    done = 1'b0; rdata = 32'd0;
    exp_q.push_back(model2[1]);
    @(posedge clk); #1;
    address = 32'hBFC00004; read2 = 1'b1;
    @(posedge clk); #1 address = 32'hBFC00008;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (waitrequest2 === 1'b0) begin rdata = readdata2; done = 1'b1; break; end
    end
    @(posedge clk); #1 read2 = 1'b0;
    $display("xfer dut2 read addr bfc00004 changed to bfc00008 mid-stall -> rdata=%h", rdata);
    exp = exp_q.pop_front();
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL addr_change_done: got %b want 1", done); end
    n_checks++; if (rdata !== exp) begin n_errors++; $display("FAIL addr_change_data: got %h want %h", rdata, exp); end
    n_checks++; if (err2 !== 1'b1) begin n_errors++; $display("FAIL addr_change_err: got %b want 1", err2); end
  endtask

  task automatic test_stall_reset();
    logic [31:0] rdata, exp; int waits; bit stray;
    @(posedge clk); #1;
    address = 32'hBFC00004; writedata = 32'hCAFEF00D; byteenable = 4'hF; write2 = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0; write2 = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    $display("xfer dut2 write cafef00d abandoned by reset during stall");
    n_checks++; if (waitrequest2 !== 1'b1) begin n_errors++; $display("FAIL sr_wait: got %b want 1", waitrequest2); end
    n_checks++; if (readdata2 !== 32'd0) begin n_errors++; $display("FAIL sr_rdata: got %h want 0", readdata2); end
    n_checks++; if (err2 !== 1'b0) begin n_errors++; $display("FAIL sr_err: got %b want 0", err2); end
    exp_q.push_back(model2[1]);
    bus_xfer(1, 1'b1, 1'b0, 32'hBFC00004, 32'd0, 4'h0, rdata, waits, stray);
    exp = exp_q.pop_front();
    n_checks++; if (rdata !== exp) begin n_errors++; $display("FAIL sr_old_word: got %h want %h", rdata, exp); end
  endtask

  task automatic test_wait0();
    logic [31:0] rdata, exp; int waits; bit stray;
    bus_xfer(0, 1'b0, 1'b1, 32'hBFC00000, 32'hA5A50001, 4'hF, rdata, waits, stray);
    model0[0] = 32'hA5A50001;
    n_checks++; if (waits !== 1) begin n_errors++; $display("FAIL w0_write_stall: got %0d want 1", waits); end
    exp_q.push_back(model0[0]);
    bus_xfer(0, 1'b1, 1'b0, 32'hBFC00000, 32'd0, 4'h0, rdata, waits, stray);
    exp = exp_q.pop_front();
    n_checks++; if (waits !== 1) begin n_errors++; $display("FAIL w0_read_stall: got %0d want 1", waits); end
    n_checks++; if (rdata !== exp) begin n_errors++; $display("FAIL w0_read_data: got %h want %h", rdata, exp); end
  endtask

  task automatic test_back_to_back();
    int done_cyc[2]; logic [31:0] got[2]; int n_done; logic [31:0] exp;
    n_done = 0; done_cyc[0] = -1; done_cyc[1] = -1; got[0] = 32'd0; got[1] = 32'd0;
    exp_q.push_back(model0[0]);
    exp_q.push_back(model0[0]);
    @(posedge clk); #1;
    address = 32'hBFC00000; read0 = 1'b1;
    for (int i = 0; i < 20 && n_done < 2; i++) begin
      @(negedge clk);
      if (waitrequest0 === 1'b0) begin done_cyc[n_done] = i; got[n_done] = readdata0; n_done++; end
    end
    @(posedge clk); #1 read0 = 1'b0;
    $display("xfer dut0 back-to-back reads completed at cycles %0d and %0d", done_cyc[0], done_cyc[1]);
    n_checks++; if (done_cyc[0] !== 1) begin n_errors++; $display("FAIL b2b_first: got %0d want 1", done_cyc[0]); end
    n_checks++; if (done_cyc[1] - done_cyc[0] !== 2) begin n_errors++; $display("FAIL b2b_spacing: got %0d want 2", done_cyc[1] - done_cyc[0]); end
    for (int k = 0; k < 2; k++) begin
      exp = exp_q.pop_front();
      n_checks++; if (got[k] !== exp) begin n_errors++; $display("FAIL b2b_data%0d: got %h want %h", k, got[k], exp); end
    end
    n_checks++; if (err0 !== 1'b0) begin n_errors++; $display("FAIL b2b_err: got %b want 0", err0); end
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_partial_write();
    test_range();
    test_rw_both();
    test_drop();
    test_addr_change();
    test_stall_reset();
    test_wait0();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

endmodule
